multiplicador_seq_4x4: RTL and testbench
========================================

// Module: multiplicador_seq_4x4
// PURPOSE
//   Unsigned sequential shift-and-add multiplier. It consumes one partial-product row per clock:
//   operand A AND-ed with a single bit B[i].
//   Sits directly downstream of the partial-product row generator, and accumulates its rows into an
//   8-bit product over N cycles.
//   Start/busy/done handshake toward the surrounding datapath/controller.
// PARAMETERS
//   N      4   operand width in bits; product width is 2*N. Only N=4 is supported.
//               The PP instance is fixed at 4 bits; any other value must be caught by an
//               elaboration-time check.
// PORTS
//   clk    in   1    single clock, all state updates on rising edge
//   rst    in   1    asynchronous, active-high reset
//   start  in   1    request a multiply; sampled only while idle
//   A      in   N    multiplicand, captured when start accepted
//   B      in   N    multiplier, captured when start accepted
//   busy   out  1    high while a multiply is in progress
//   done   out  1    one-cycle pulse: P holds a new result
//   P      out  2N   product A*B, held until next accepted start completes
// BEHAVIOUR
//   Reset (async, any time, incl. mid-operation):
//     - state=IDLE; areg, breg, acc, cnt, P all 0; busy=0, done=0.
//     - An in-flight multiply is discarded; no done pulse follows.
//   FSM states: IDLE, RUN (2 states; encodings in shared include).
//   IDLE:
//     - start=1 at edge t0: areg<=A, breg<=B, acc<=0, cnt<=0, busy<=1, state<=RUN.
//     - start=0: hold; P keeps its last value.
//   RUN, each edge:
//     - pp = areg & {N{breg[cnt]}} (PP row instance).
//     - acc <= acc + (pp << cnt), where pp is zero-extended to 2N before the shift.
//     - cnt <= cnt+1.
//   RUN, on the edge where cnt==N-1 (edge t0+N):
//     - P <= acc + (pp<<cnt), done<=1, busy<=0, state<=IDLE.
//   Latency and pulse timing:
//     - start accepted at t0 -> done high during the cycle after edge t0+N, i.e. N cycles of RUN.
//     - done is high for exactly one cycle; it is cleared at the next edge unconditionally.
//   Back-to-back: start=1 in the done cycle is accepted (FSM is IDLE); busy rises again next edge.
//   Ignored inputs:
//     - start while busy=1 is ignored; the request is not queued.
//     - A/B changes during RUN have no effect on the current result.
//   Arithmetic: unsigned, 2N-bit accumulator, no overflow possible (max 15*15=225 < 256).
//   cnt width: clog2(N) bits; it never wraps past N-1 while in RUN.
//   B=0 or A=0: still takes the full N cycles; result 0.
// STRUCTURE
//   Shared include (mult_defs.vh): N default, FSM state encodings (IDLE=1'b0, RUN=1'b1).
//   One sub-module: ProdutoParcial (4-bit AND row, inputs areg and breg[cnt], output pp).
//   Everything else lives in this file:
//     - multiplier-bit mux
//     - shifter
//     - 8-bit adder
//     - FSM/counter registers
// TESTING
//   1. rst pulse, no start -> P=0x00, busy=0, done=0 and stay so for 10 cycles.
//   2. A=9, B=6, start 1 cycle -> busy for 4 cycles, done pulse once, P=0x36 (54).
//   3. A=15, B=15 -> P=0xE1 (225). A=0, B=13 -> P=0x00 after full 4-cycle latency.
//   4. A=3, B=5 start; while busy, drive start=1 with A=7, B=7 ->
//      P=0x0F; only one done pulse; second request dropped.
//   5. Back-to-back: A=2,B=3 then start=1 in its done cycle with A=4,B=4 ->
//      P=0x06 then P=0x10, done pulses 5 cycles apart.
//   6. A=11,B=11 start, assert rst after 2 RUN cycles ->
//      P=0, busy=0 immediately (async), no done pulse; next A=1,B=1 gives P=0x01.

Source files
------------

// File: rtl/multiplicador_seq_4x4_pkg.sv
// Shared definitions for the sequential 4x4 shift-and-add multiplier.
//   N_DEFAULT : operand width (only 4 is supported by the partial-product row)
//   ST_IDLE   : FSM waiting for start
//   ST_RUN    : FSM accumulating one partial-product row per clock
package multiplicador_seq_4x4_pkg;

    localparam int N_DEFAULT = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/multiplicador_seq_4x4_if.sv
// Start/busy/done handshake bundle between a controller and the multiplier.
//   start : request a multiply (controller -> multiplier)
//   a, b  : multiplicand / multiplier, captured when start is accepted
//   busy  : multiply in progress (multiplier -> controller)
//   done  : one-cycle pulse, p holds a new result
//   p     : 2N-bit product, held until the next multiply completes
// Modports: master = controller side, slave = multiplier side.
interface multiplicador_seq_4x4_if
    import multiplicador_seq_4x4_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   p;

    modport master (
        output start, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b,
        output busy, done, p
    );

endinterface

// File: rtl/multiplicador_seq_4x4_produto_parcial.sv
// Partial-product row: the multiplicand AND-ed with a single multiplier bit.
//   a     : 4-bit multiplicand
//   b_bit : selected multiplier bit
//   pp    : a when b_bit=1, zero otherwise
module multiplicador_seq_4x4_produto_parcial
    import multiplicador_seq_4x4_pkg::*;
(
    input  logic [N_DEFAULT-1:0] a,
    input  logic                 b_bit,
    output logic [N_DEFAULT-1:0] pp
);

    assign pp = a & {N_DEFAULT{b_bit}};

endmodule

// File: rtl/multiplicador_seq_4x4.sv
// Unsigned sequential shift-and-add multiplier, one partial-product row per clock.
// A multiply takes N clocks of RUN after start is accepted; done pulses for one
// cycle as the result lands in p, which then holds until the next result.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards any in-flight multiply
//   bus : handshake/data bundle (slave side): start, a, b in; busy, done, p out
module multiplicador_seq_4x4
    import multiplicador_seq_4x4_pkg::*;
#(
    parameter int N = N_DEFAULT
)(
    input  logic                      clk,
    input  logic                      rst,
    multiplicador_seq_4x4_if.slave    bus
);

    localparam int PW    = 2 * N;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    // The partial-product row is a fixed 4-bit block; reject other widths early.
    if (N != 4) begin : g_width_check
        $error("multiplicador_seq_4x4: only N=4 is supported");
    end

    logic [0:0]        state;
    logic [N-1:0]      areg;
    logic [N-1:0]      breg;
    logic [PW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;
    logic [PW-1:0]     p_q;
    logic              busy_q;
    logic              done_q;

    logic              b_bit;
    logic [N-1:0]      pp;
    logic [PW-1:0]     pp_shifted;
    logic [PW-1:0]     sum;

    // Multiplier-bit mux: cnt walks breg from LSB to MSB.
    assign b_bit = breg[cnt];

    multiplicador_seq_4x4_produto_parcial u_pp (
        .a     (areg),
        .b_bit (b_bit),
        .pp    (pp)
    );

    // Zero-extend the row to product width before weighting it by its bit position.
    assign pp_shifted = {{N{1'b0}}, pp} << cnt;
    assign sum        = acc + pp_shifted;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every register, including the visible product, is reset;
            // there is no memory array here, so nothing is left uninitialised.
            state  <= ST_IDLE;
            areg   <= '0;
            breg   <= '0;
            acc    <= '0;
            cnt    <= '0;
            p_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // done is a single-cycle pulse regardless of what follows.
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        areg   <= bus.a;
                        breg   <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // start is not looked at here, so requests while busy are dropped.
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        p_q    <= sum;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;

endmodule

// File: tb/tb_multiplicador_seq_4x4.sv
// Self-checking bench for multiplicador_seq_4x4. Expected products come from
// plain integer multiplication; expected timing is N clocks from accept to done.
module tb_multiplicador_seq_4x4;

    localparam int N      = 4;
    localparam int PERIOD = 10;
    localparam int BOUND  = 20;

    logic clk = 1'b0;
    logic rst;

    always #(PERIOD / 2) clk = ~clk;

    multiplicador_seq_4x4_if #(.N(N)) bus ();

    multiplicador_seq_4x4 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge: present operands and pulse start across one rising edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called on the negedge after the accepting edge; returns rising edges
    // until done is seen and how many of those cycles showed busy.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges < BOUND) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
        int edges;
        int busy_cycles;
        int expected;
        expected = int'(a) * int'(b);
        start_op(a, b);
        wait_done(edges, busy_cycles);
        check({tag, " latency"}, edges, N);
        check({tag, " busy_cycles"}, busy_cycles, N);
        check({tag, " product"}, bus.p, expected);
        check({tag, " busy_at_done"}, bus.busy, 0);
        @(negedge clk);
        check({tag, " done_cleared"}, bus.done, 0);
        check({tag, " product_held"}, bus.p, expected);
    endtask

    initial begin
        int pulses;
        int edges;
        int busy_cycles;
        time t_first;
        time t_second;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("reset p", bus.p, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        rst = 1'b0;

        // Idle with no start: outputs stay quiet.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle quiet", {bus.p, bus.busy, bus.done}, 0);
        end

        run_op("9x6", 4'd9, 4'd6);
        check("9x6 literal", bus.p, 32'h36);
        run_op("15x15", 4'd15, 4'd15);
        check("15x15 literal", bus.p, 32'hE1);
        run_op("0x13", 4'd0, 4'd13);

        // Start while busy is dropped, and A/B changes during RUN do not matter.
        start_op(4'd3, 4'd5);
        bus.a     = 4'd7;
        bus.b     = 4'd7;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done === 1'b1) begin
                pulses++;
                check("busy_drop product", bus.p, 32'h0F);
            end
            @(negedge clk);
        end
        check("busy_drop pulses", pulses, 1);
        check("busy_drop held", bus.p, 32'h0F);

        // Back-to-back: second start issued during the first done cycle.
        start_op(4'd2, 4'd3);
        wait_done(edges, busy_cycles);
        t_first = $time;
        check("b2b first product", bus.p, 6);
        check("b2b first latency", edges, N);
        start_op(4'd4, 4'd4);
        check("b2b busy_rises", bus.busy, 1);
        wait_done(edges, busy_cycles);
        t_second = $time;
        check("b2b second product", bus.p, 16);
        check("b2b done_spacing", int'((t_second - t_first) / PERIOD), N + 1);
        @(negedge clk);

        // Asynchronous reset two RUN cycles into a multiply.
        start_op(4'd11, 4'd11);
        repeat (2) @(negedge clk);
        check("abort busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("abort p_async", bus.p, 0);
        check("abort busy_async", bus.busy, 0);
        check("abort done_async", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done === 1'b1) pulses++;
            @(negedge clk);
        end
        check("abort no_done", pulses, 0);
        check("abort p_stays", bus.p, 0);
        run_op("1x1", 4'd1, 4'd1);

        // Randomised operands against integer multiplication.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(15));
            rb = 4'($urandom_range(15));
            run_op($sformatf("rand%0d %0dx%0d", i, ra, rb), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
